// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file write-back controller.
package rf_wb_pkg;

    localparam int XLEN_DEF     = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int NUM_REGS     = 1 << REG_ADDR_W;
    localparam int STARVE_CNT_W = 4;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } arb_state_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
        reg_onehot    = '0;
        reg_onehot[r] = 1'b1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending scoreboard and issue hazard check.
// Build option RF_WB_BYPASS_EN: a write in the write stage releases its register early.
module rf_scoreboard
    import rf_wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  halt,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic [REG_ADDR_W-1:0] iss_rs1,
    input  logic [REG_ADDR_W-1:0] iss_rs2,
    output logic                  iss_ok,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    output logic [NUM_REGS-1:0]   pending
);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [NUM_REGS-1:0] busy;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        busy = pending_q;
`ifdef RF_WB_BYPASS_EN
        if (wr_en) begin
            busy = pending_q & ~reg_onehot(wr_addr);
        end
`endif
        // x0 needs no explicit mask: its pending bit is never set.
        iss_ok = !halt && !busy[iss_rs1] && !busy[iss_rs2] && !busy[iss_rd];

        pending_d = pending_q;
        if (!halt) begin
            if (wr_en) begin
                pending_d = pending_d & ~reg_onehot(wr_addr);
            end
            // Applied after the clear so a same-cycle set on the same register wins.
            if (iss_valid && iss_ok) begin
                pending_d = pending_d | reg_onehot(iss_rd);
            end
        end
        pending_d[0] = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back arbiter (ALU path A vs load path B with starvation guard) feeding the register file.
// Build option RF_WB_BYPASS_EN enables early scoreboard release (see rf_scoreboard).
module regfile_wb_ctrl
    import rf_wb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = XLEN_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  halt,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [REG_ADDR_W-1:0] a_rd,
    input  logic [XLEN-1:0]       a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [REG_ADDR_W-1:0] b_rd,
    input  logic [XLEN-1:0]       b_data,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic [REG_ADDR_W-1:0] iss_rs1,
    input  logic [REG_ADDR_W-1:0] iss_rs2,
    output logic                  iss_ok,
    output logic                  rf_wr_en,
    output logic [REG_ADDR_W-1:0] rf_wr_addr,
    output logic [XLEN-1:0]       rf_wr_data,
    output logic [NUM_REGS-1:0]   pending
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(STARVE_LIMIT);
    localparam logic [STARVE_CNT_W-1:0] CNT_MAX = '1;

    arb_state_e              state_q, state_d;
    logic [STARVE_CNT_W-1:0] starve_q, starve_d;
    logic                    wr_en_q, wr_en_d;
    logic [REG_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]         wr_data_q, wr_data_d;
    logic                    a_hs, b_hs;

    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!halt) begin
            case (state_q)
                PRIO_A: begin
                    a_ready = a_valid;
                    b_ready = b_valid && !a_valid;
                end
                PRIO_B: begin
                    b_ready = b_valid;
                    a_ready = a_valid && !b_valid;
                end
                default: ;
            endcase
        end
        a_hs = a_valid && a_ready;
        b_hs = b_valid && b_ready;

        starve_d = starve_q;
        if (b_hs) begin
            starve_d = '0;
        end else if (!halt && b_valid && starve_q != CNT_MAX) begin
            starve_d = starve_q + 1'b1;
        end

        // Comparing the updated count grants B on its (STARVE_LIMIT+1)-th waiting cycle.
        state_d = state_q;
        if (!halt) begin
            case (state_q)
                PRIO_A:  if (b_valid && starve_d == LIMIT_C) state_d = PRIO_B;
                PRIO_B:  if (b_hs || !b_valid)               state_d = PRIO_A;
                default: state_d = PRIO_A;
            endcase
        end

        // Handshakes to x0 complete without producing a write strobe.
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (a_hs && a_rd != '0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = a_rd;
            wr_data_d = a_data;
        end else if (b_hs && b_rd != '0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = b_rd;
            wr_data_d = b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PRIO_A;
            starve_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign rf_wr_en   = wr_en_q;
    assign rf_wr_addr = wr_addr_q;
    assign rf_wr_data = wr_data_q;

    rf_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .halt     (halt),
        .iss_valid(iss_valid),
        .iss_rd   (iss_rd),
        .iss_rs1  (iss_rs1),
        .iss_rs2  (iss_rs2),
        .iss_ok   (iss_ok),
        .wr_en    (wr_en_q),
        .wr_addr  (wr_addr_q),
        .pending  (pending)
    );

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed plus randomized bench for regfile_wb_ctrl against a behavioural reference model.
module tb_regfile_wb_ctrl;

    localparam int LIMIT = 4;
`ifdef RF_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, halt;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [4:0]  a_rd, b_rd, iss_rd, iss_rs1, iss_rs2, rf_wr_addr;
    logic [31:0] a_data, b_data, rf_wr_data, pending;
    logic        iss_valid, iss_ok, rf_wr_en;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit          m_prio_b;
    int          m_cnt;
    logic [31:0] m_pend;
    bit          m_wr_en;
    logic [4:0]  m_wr_addr;
    logic [31:0] m_wr_data;
    bit          e_a, e_b, e_ok;

    // Values observed away from the clock edge in the last step
    logic obs_a_ready, obs_b_ready, obs_iss_ok, obs_wr_en;

    always #5 clk = ~clk;

    regfile_wb_ctrl #(.STARVE_LIMIT(LIMIT), .XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .halt      (halt),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_rd      (a_rd),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_rd      (b_rd),
        .b_data    (b_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_ok    (iss_ok),
        .rf_wr_en  (rf_wr_en),
        .rf_wr_addr(rf_wr_addr),
        .rf_wr_data(rf_wr_data),
        .pending   (pending)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit reg_busy(input logic [4:0] r);
        return r != 5'd0 && m_pend[r] && !(BYPASS && m_wr_en && m_wr_addr == r);
    endfunction

    task automatic model_reset();
        m_prio_b  = 1'b0;
        m_cnt     = 0;
        m_pend    = '0;
        m_wr_en   = 1'b0;
        m_wr_addr = '0;
        m_wr_data = '0;
    endtask

    task automatic model_comb();
        e_a = 1'b0;
        e_b = 1'b0;
        if (!halt) begin
            if (m_prio_b) begin
                e_b = b_valid;
                e_a = a_valid && !b_valid;
            end else begin
                e_a = a_valid;
                e_b = b_valid && !a_valid;
            end
        end
        e_ok = !halt && !reg_busy(iss_rs1) && !reg_busy(iss_rs2) && !reg_busy(iss_rd);
    endtask

    task automatic model_seq();
        bit          a_hs, b_hs;
        int          c;
        logic [31:0] np;
        if (rst) begin
            model_reset();
        end else if (halt) begin
            m_wr_en = 1'b0;
        end else begin
            a_hs = a_valid && e_a;
            b_hs = b_valid && e_b;
            np = m_pend;
            if (m_wr_en) np[m_wr_addr] = 1'b0;
            if (iss_valid && e_ok && iss_rd != 5'd0) np[iss_rd] = 1'b1;
            m_pend = np;
            if (b_hs) c = 0;
            else if (b_valid) c = (m_cnt < 15) ? m_cnt + 1 : 15;
            else c = m_cnt;
            if (!m_prio_b) m_prio_b = b_valid && (c == LIMIT);
            else m_prio_b = !(b_hs || !b_valid);
            m_cnt = c;
            m_wr_en = 1'b0;
            if (a_hs && a_rd != 5'd0) begin
                m_wr_en = 1'b1; m_wr_addr = a_rd; m_wr_data = a_data;
            end else if (b_hs && b_rd != 5'd0) begin
                m_wr_en = 1'b1; m_wr_addr = b_rd; m_wr_data = b_data;
            end
        end
    endtask

    // One clock: check combinational outputs at negedge, registered outputs 1 time unit after posedge.
    task automatic step();
        @(negedge clk);
        model_comb();
        obs_a_ready = a_ready;
        obs_b_ready = b_ready;
        obs_iss_ok  = iss_ok;
        obs_wr_en   = rf_wr_en;
        check("a_ready", {31'd0, a_ready}, {31'd0, e_a});
        check("b_ready", {31'd0, b_ready}, {31'd0, e_b});
        check("iss_ok", {31'd0, iss_ok}, {31'd0, e_ok});
        @(posedge clk);
        model_seq();
        #1;
        check("rf_wr_en", {31'd0, rf_wr_en}, {31'd0, m_wr_en});
        check("pending", pending, m_pend);
        if (m_wr_en) begin
            check("rf_wr_addr", {27'd0, rf_wr_addr}, {27'd0, m_wr_addr});
            check("rf_wr_data", rf_wr_data, m_wr_data);
        end
    endtask

    task automatic set_in(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                          input bit bv, input logic [4:0] brd, input logic [31:0] bd,
                          input bit iv, input logic [4:0] ird, input logic [4:0] irs1,
                          input logic [4:0] irs2, input bit h, input bit r);
        a_valid = av; a_rd = ard; a_data = ad;
        b_valid = bv; b_rd = brd; b_data = bd;
        iss_valid = iv; iss_rd = ird; iss_rs1 = irs1; iss_rs2 = irs2;
        halt = h; rst = r;
    endtask

    initial begin
        bit ra[8];
        bit rb[8];
        int b_at, na;

        model_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        step();
        check("rst_wr_en", {31'd0, rf_wr_en}, 32'd0);
        check("rst_wr_addr", {27'd0, rf_wr_addr}, 32'd0);
        check("rst_wr_data", rf_wr_data, 32'd0);
        check("rst_pending", pending, 32'd0);

        // Single A write
        set_in(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check("a_wr_ready", {31'd0, obs_a_ready}, 32'd1);
        check("a_wr_en", {31'd0, rf_wr_en}, 32'd1);
        check("a_wr_addr", {27'd0, rf_wr_addr}, 32'd5);
        check("a_wr_data", rf_wr_data, 32'hDEADBEEF);

        // x0 discard on the B path
        set_in(0, 0, 0, 1, 0, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
        step();
        check("x0_b_ready", {31'd0, obs_b_ready}, 32'd1);
        check("x0_wr_en", {31'd0, rf_wr_en}, 32'd0);
        check("x0_pending", pending, 32'd0);

        // Starvation: both requesters held
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        b_at = -1;
        na = 0;
        for (int i = 0; i < 8; i++) begin
            set_in(1, 5'(1 + (i % 7)), $urandom, 1, 5'(8 + i), $urandom, 0, 0, 0, 0, 0, 0);
            step();
            ra[i] = obs_a_ready;
            rb[i] = obs_b_ready;
            if (obs_b_ready && b_at < 0) b_at = i;
            else if (obs_a_ready && b_at < 0) na++;
        end
        check("starve_a_grants", na, LIMIT);
        check("starve_b_cycle", b_at, LIMIT);
        check("starve_back_to_a", {31'd0, ra[LIMIT+1]}, 32'd1);
        check("starve_b_once", {31'd0, rb[LIMIT+1]}, 32'd0);

        // RAW hazard on x7
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        set_in(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
        step();
        check("haz_issue_ok", {31'd0, obs_iss_ok}, 32'd1);
        check("haz_pending_set", pending, 32'h80);
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 7, 0, 0, 0);
        step();
        check("haz_stall0", {31'd0, obs_iss_ok}, 32'd0);
        step();
        check("haz_stall1", {31'd0, obs_iss_ok}, 32'd0);
        set_in(1, 7, 32'h0BAD_F00D, 0, 0, 0, 1, 0, 7, 0, 0, 0);
        step();
        check("haz_n", {31'd0, obs_iss_ok}, 32'd0);
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 7, 0, 0, 0);
        step();
        check("haz_n1_wr_en", {31'd0, obs_wr_en}, 32'd1);
        check("haz_n1", {31'd0, obs_iss_ok}, {31'd0, BYPASS});
        check("haz_cleared", pending, 32'd0);
        step();
        check("haz_n2", {31'd0, obs_iss_ok}, 32'd1);

        // Halt freezes arbitration and scoreboard
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        set_in(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 3, $urandom, 1, 4, $urandom, 0, 0, 0, 0, 0, 0);
            step();
        end
        set_in(1, 3, $urandom, 1, 4, $urandom, 1, 2, 0, 0, 1, 0);
        step();
        check("halt_a_ready", {31'd0, obs_a_ready}, 32'd0);
        check("halt_b_ready", {31'd0, obs_b_ready}, 32'd0);
        check("halt_iss_ok", {31'd0, obs_iss_ok}, 32'd0);
        check("halt_inflight", {31'd0, obs_wr_en}, 32'd1);
        check("halt_wr_en", {31'd0, rf_wr_en}, 32'd0);
        check("halt_pending", pending, 32'h200);
        step();
        check("halt_pending2", pending, 32'h200);
        set_in(1, 3, $urandom, 1, 4, $urandom, 0, 0, 0, 0, 0, 0);
        step();
        check("resume_a", {31'd0, obs_a_ready}, 32'd1);
        step();
        check("resume_b", {31'd0, obs_b_ready}, 32'd1);

        // Reset mid-stream with a pending bit, PRIO_B and a write in flight
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        set_in(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0);
        step();
        for (int i = 0; i < LIMIT; i++) begin
            set_in(1, 4, $urandom, 1, 6, $urandom, 0, 0, 0, 0, 0, 0);
            step();
        end
        check("mid_pending", pending, 32'h80);
        check("mid_inflight", {31'd0, rf_wr_en}, 32'd1);
        set_in(1, 4, $urandom, 1, 6, $urandom, 0, 0, 0, 0, 0, 1);
        step();
        check("mid_rst_pending", pending, 32'd0);
        check("mid_rst_wr_en", {31'd0, rf_wr_en}, 32'd0);
        set_in(1, 4, $urandom, 1, 6, $urandom, 0, 0, 0, 0, 0, 0);
        step();
        check("mid_rst_prio_a", {31'd0, obs_a_ready}, 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            set_in(bit'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                   bit'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                   bit'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
